// File: rtl/cnt_pkg.sv
// Shared types and helpers for the modulo up/down counter family.
package cnt_pkg;

  typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;

  localparam int CNT_MAX_WIDTH = 32;

  function automatic logic [CNT_MAX_WIDTH-1:0] bin2gray(input logic [CNT_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/cnt_step.sv
// Combinational next-count and range-limit detection for one counting step.
module cnt_step
  import cnt_pkg::*;
#(
  parameter int     WIDTH   = 3,
  parameter longint MODULUS = longint'(1) << WIDTH
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_up_dn,
  input  cnt_mode_e        i_mode,
  output logic [WIDTH-1:0] o_next,
  output logic             o_at_limit
);

  localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MODULUS - 1);

  logic [WIDTH:0] w_ext;
  assign w_ext = {1'b0, i_count};

  always_comb begin
    o_at_limit = i_up_dn ? (i_count == MAX_N) : (i_count == '0);
    o_next     = i_up_dn ? WIDTH'(w_ext + 1'b1) : WIDTH'(w_ext - 1'b1);
    if (o_at_limit) begin
      // Saturate holds at the limit; wrap jumps to the opposite end.
      if (i_mode == CNT_SAT) o_next = i_count;
      else                   o_next = i_up_dn ? '0 : MAX_N;
    end
  end

endmodule

// File: rtl/mod_counter_updn.sv
// Modulo-N up/down counter with clear, load, wrap/saturate mode and Gray output.
module mod_counter_updn
  import cnt_pkg::*;
#(
  parameter int     WIDTH     = 3,
  parameter longint MODULUS   = longint'(1) << WIDTH,
  parameter bit     SATURATE  = 1'b0,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_gray,
  output logic             tc,
  output logic             wrap,
  output logic             sat,
  output logic             load_err
);

  if (WIDTH < 1 || WIDTH > CNT_MAX_WIDTH) begin : g_bad_width
    $fatal(1, "mod_counter_updn: WIDTH out of range");
  end
  if (MODULUS < 2) begin : g_bad_mod_lo
    $fatal(1, "mod_counter_updn: MODULUS must be >= 2");
  end
  if (MODULUS > (longint'(1) << WIDTH)) begin : g_bad_mod_hi
    $fatal(1, "mod_counter_updn: MODULUS exceeds 2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
    $fatal(1, "mod_counter_updn: RESET_VAL must be < MODULUS");
  end

  localparam cnt_mode_e        MODE  = SATURATE ? CNT_SAT : CNT_WRAP;
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_G = WIDTH'(bin2gray(CNT_MAX_WIDTH'(RST_V)));

  logic [WIDTH-1:0] r_count, r_gray;
  logic             r_wrap, r_sat, r_load_err;

  logic [WIDTH-1:0] w_next, w_count_d;
  logic             w_at_limit, w_wrap_d, w_sat_d, w_load_err_d;

  cnt_step #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_step (
    .i_count    (r_count),
    .i_up_dn    (up_dn),
    .i_mode     (MODE),
    .o_next     (w_next),
    .o_at_limit (w_at_limit)
  );

  // Priority: clear > load > en > hold (reset handled in the register stage).
  always_comb begin
    w_count_d    = r_count;
    w_wrap_d     = 1'b0;
    w_sat_d      = r_sat;
    w_load_err_d = 1'b0;
    if (clear) begin
      w_count_d = RST_V;
      w_sat_d   = 1'b0;
    end else if (load) begin
      if ({1'b0, load_val} < MOD_W) begin
        w_count_d = load_val;
        w_sat_d   = 1'b0;
      end else begin
        w_load_err_d = 1'b1;
      end
    end else if (en) begin
      w_count_d = w_next;
      w_wrap_d  = w_at_limit && (MODE == CNT_WRAP);
      w_sat_d   = w_at_limit && (MODE == CNT_SAT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= RST_V;
      r_gray     <= RST_G;
      r_wrap     <= 1'b0;
      r_sat      <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= w_count_d;
      r_gray     <= WIDTH'(bin2gray(CNT_MAX_WIDTH'(w_count_d)));
      r_wrap     <= w_wrap_d;
      r_sat      <= w_sat_d;
      r_load_err <= w_load_err_d;
    end
  end

  assign count      = r_count;
  assign count_gray = r_gray;
  assign tc         = w_at_limit;
  assign wrap       = r_wrap;
  assign sat        = r_sat;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_mod_counter_updn.sv
// Scoreboard bench: three counter configurations (mod-8 wrap, mod-6 wrap, mod-8 saturate).
module tb_mod_counter_updn;

  logic       clk = 1'b0;
  logic       rst_n_a[3];
  logic       en_a[3], up_a[3], clr_a[3], ld_a[3];
  logic [2:0] lv_a[3];
  logic [2:0] cnt_a[3], gray_a[3];
  logic       tc_a[3], wrap_a[3], sat_a[3], lerr_a[3];

  always #5 clk = ~clk;

  mod_counter_updn #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0), .RESET_VAL(0)) u_d0 (
    .clk(clk), .rst_n(rst_n_a[0]), .en(en_a[0]), .up_dn(up_a[0]), .clear(clr_a[0]),
    .load(ld_a[0]), .load_val(lv_a[0]), .count(cnt_a[0]), .count_gray(gray_a[0]),
    .tc(tc_a[0]), .wrap(wrap_a[0]), .sat(sat_a[0]), .load_err(lerr_a[0]));

  mod_counter_updn #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b0), .RESET_VAL(0)) u_d1 (
    .clk(clk), .rst_n(rst_n_a[1]), .en(en_a[1]), .up_dn(up_a[1]), .clear(clr_a[1]),
    .load(ld_a[1]), .load_val(lv_a[1]), .count(cnt_a[1]), .count_gray(gray_a[1]),
    .tc(tc_a[1]), .wrap(wrap_a[1]), .sat(sat_a[1]), .load_err(lerr_a[1]));

  mod_counter_updn #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b1), .RESET_VAL(0)) u_d2 (
    .clk(clk), .rst_n(rst_n_a[2]), .en(en_a[2]), .up_dn(up_a[2]), .clear(clr_a[2]),
    .load(ld_a[2]), .load_val(lv_a[2]), .count(cnt_a[2]), .count_gray(gray_a[2]),
    .tc(tc_a[2]), .wrap(wrap_a[2]), .sat(sat_a[2]), .load_err(lerr_a[2]));

  typedef struct {
    int    id;
    int    cnt;
    logic  tc, wrap, sat, lerr;
    string nm;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, f, act, exp);
    end
  endtask

  // Drive one cycle on DUT id; the expected post-edge state goes to the scoreboard.
  task automatic step(input int id, input logic rst, input logic e, input logic u,
                      input logic c, input logic l, input logic [2:0] lv,
                      input int cnt, input logic tc, input logic w, input logic s,
                      input logic le, input string nm);
    exp_t x;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      en_a[k] = 1'b0; clr_a[k] = 1'b0; ld_a[k] = 1'b0;
    end
    rst_n_a[id] = ~rst;
    en_a[id] = e; up_a[id] = u; clr_a[id] = c; ld_a[id] = l; lv_a[id] = lv;
    x.id = id; x.cnt = cnt; x.tc = tc; x.wrap = w; x.sat = s; x.lerr = le; x.nm = nm;
    q.push_back(x);
  endtask

  // Monitor: the counter presents a new state every edge; compare just after it.
  initial begin
    exp_t e;
    int   g;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        g = e.cnt ^ (e.cnt >> 1);
        chk(e.nm, "count", 32'(cnt_a[e.id]),  e.cnt);
        chk(e.nm, "gray",  32'(gray_a[e.id]), g);
        chk(e.nm, "tc",    32'(tc_a[e.id]),   32'(e.tc));
        chk(e.nm, "wrap",  32'(wrap_a[e.id]), 32'(e.wrap));
        chk(e.nm, "sat",   32'(sat_a[e.id]),  32'(e.sat));
        chk(e.nm, "lerr",  32'(lerr_a[e.id]), 32'(e.lerr));
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n_a[k] = 1'b0; en_a[k] = 1'b0; up_a[k] = 1'b1;
      clr_a[k] = 1'b0; ld_a[k] = 1'b0; lv_a[k] = 3'd0;
    end

    // DUT0: mod 8 wrap, up-count through the wrap
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "d0_rst");
    for (int i = 1; i <= 9; i++)
      step(0, 0, 1, 1, 0, 0, 0, i % 8, (i % 8) == 7, i == 8, 0, 0, "d0_up");
    step(0, 0, 1, 1, 0, 1, 5, 5, 0, 0, 0, 0, "d0_load_no_step");
    step(0, 0, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0, "d0_dn");
    step(0, 0, 1, 1, 1, 1, 2, 0, 0, 0, 0, 0, "d0_clr_pri");
    step(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, "d0_up1");
    step(0, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0, "d0_up2");
    step(0, 0, 1, 1, 0, 0, 0, 3, 0, 0, 0, 0, "d0_up3");
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "d0_rst_mid");
    // en toggling with a direction flip while disabled
    step(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, "d0_tog_en1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "d0_tog_en0");
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "d0_tog_dn");
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "d0_tog_hold");
    step(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, "d0_tog_up");
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "d0_dn_to0");
    step(0, 0, 1, 0, 0, 0, 0, 7, 0, 1, 0, 0, "d0_dn_wrap");
    step(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, "d0_wrap_drop");
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, "d0_up_wrap");
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "d0_rst_flags");

    // DUT1: mod 6 wrap, down-count and load range checks
    step(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "d1_rst");
    begin
      int seq[8] = '{5, 4, 3, 2, 1, 0, 5, 4};
      for (int i = 0; i < 8; i++)
        step(1, 0, 1, 0, 0, 0, 0, seq[i], seq[i] == 0, seq[i] == 5, 0, 0, "d1_dn");
    end
    step(1, 0, 1, 0, 0, 1, 7, 4, 0, 0, 0, 1, "d1_load7_err");
    step(1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, "d1_err_drop");
    step(1, 0, 0, 0, 0, 1, 6, 4, 0, 0, 0, 1, "d1_load6_err");
    step(1, 0, 1, 1, 0, 1, 5, 5, 1, 0, 0, 0, "d1_load5");
    step(1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, "d1_up_wrap");
    step(1, 0, 0, 1, 0, 1, 7, 0, 0, 0, 0, 1, "d1_err_again");
    step(1, 0, 1, 1, 1, 1, 7, 0, 0, 0, 0, 0, "d1_clr");

    // DUT2: mod 8 saturate
    step(2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "d2_rst");
    for (int i = 1; i <= 9; i++)
      step(2, 0, 1, 1, 0, 0, 0, (i > 7) ? 7 : i, i >= 7, 0, i >= 8, 0, "d2_up_sat");
    step(2, 0, 1, 0, 0, 0, 0, 6, 0, 0, 0, 0, "d2_leave_sat");
    for (int i = 5; i >= 0; i--)
      step(2, 0, 1, 0, 0, 0, 0, i, i == 0, 0, 0, 0, "d2_dn");
    step(2, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, "d2_sat_lo");
    step(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "d2_sat_hold");
    step(2, 0, 1, 0, 0, 1, 3, 3, 0, 0, 0, 0, "d2_load_clr_sat");
    step(2, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, "d2_dn2");
    step(2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "d2_dn1");
    step(2, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "d2_dn0");
    step(2, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, "d2_sat_lo2");
    step(2, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, "d2_clr_sat");

    repeat (2) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
